sc_timecounter_flag: RTL

- Upstream time base for the countdown-signal state machine; produces the 8-bit elapsed-time count that the state machine compares against its window thresholds (12/16, 48/52, 95/99).
- A start-button press clears and starts the count. The count then advances once per PRESCALE clocks until COUNT_MAX.
- At COUNT_MAX it stops or wraps, per parameter. A pause input freezes the count.

---
 rtl/sc_timecounter_flag_if.sv | 28 ++
 rtl/sc_timecounter_flag.sv | 116 +++++++++++
 2 files changed

// File: rtl/sc_timecounter_flag_if.sv
// Button/pause inputs and count/status outputs of the elapsed-time counter.
// The master drives the buttons; the counter itself is the slave.
interface sc_timecounter_flag_if;
    logic       SC_TIMECOUNTER_startButton_InLow;
    logic       SC_TIMECOUNTER_pause_InLow;
    logic [7:0] SC_TIMECOUNTER_COUNT;
    logic       SC_TIMECOUNTER_TICK;
    logic       SC_TIMECOUNTER_RUNNING;
    logic       SC_TIMECOUNTER_DONE;

    modport master (
        output SC_TIMECOUNTER_startButton_InLow,
        output SC_TIMECOUNTER_pause_InLow,
        input  SC_TIMECOUNTER_COUNT,
        input  SC_TIMECOUNTER_TICK,
        input  SC_TIMECOUNTER_RUNNING,
        input  SC_TIMECOUNTER_DONE
    );

    modport slave (
        input  SC_TIMECOUNTER_startButton_InLow,
        input  SC_TIMECOUNTER_pause_InLow,
        output SC_TIMECOUNTER_COUNT,
        output SC_TIMECOUNTER_TICK,
        output SC_TIMECOUNTER_RUNNING,
        output SC_TIMECOUNTER_DONE
    );
endinterface

// File: rtl/sc_timecounter_flag.sv
// Prescaled elapsed-time counter feeding the countdown-signal state machine.
// Start button clears and starts the count; pause freezes it; stops or wraps at COUNT_MAX.
module sc_timecounter_flag #(
    parameter int unsigned PRESCALE  = 50000000,
    parameter int unsigned COUNT_MAX = 99,
    parameter bit          WRAP      = 1'b0
) (
    input  logic                        SC_TIMECOUNTER_CLOCK_50,
    input  logic                        SC_TIMECOUNTER_RESET_InLow,
    sc_timecounter_flag_if.slave        tc_if
);

    localparam logic [25:0] PRESC_LAST = 26'(PRESCALE - 1);
    localparam logic [7:0]  CNT_MAX    = 8'(COUNT_MAX);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q;
    logic [25:0] presc_q;
    logic [7:0]  count_q;
    logic        tick_q;
    logic        running_q;
    logic        done_q;

    logic [1:0]  startSync_q;
    logic [1:0]  pauseSync_q;
    logic [1:0]  syncValid_q;
    logic        startPrev_q;

    logic        startFall;
    logic        pauseActive;

    // syncValid_q keeps the preset-to-released synchronizer value from being
    // taken as a real release, so a button held low through reset cannot
    // produce a start edge until it has been seen released.
    always_ff @(posedge SC_TIMECOUNTER_CLOCK_50 or negedge SC_TIMECOUNTER_RESET_InLow) begin
        if (!SC_TIMECOUNTER_RESET_InLow) begin
            startSync_q <= 2'b11;
            pauseSync_q <= 2'b11;
            syncValid_q <= 2'b00;
            startPrev_q <= 1'b0;
        end else begin
            startSync_q <= {startSync_q[0], tc_if.SC_TIMECOUNTER_startButton_InLow};
            pauseSync_q <= {pauseSync_q[0], tc_if.SC_TIMECOUNTER_pause_InLow};
            syncValid_q <= {syncValid_q[0], 1'b1};
            startPrev_q <= syncValid_q[1] & startSync_q[1];
        end
    end

    assign startFall   = startPrev_q & ~startSync_q[1];
    assign pauseActive = ~pauseSync_q[1];

    always_ff @(posedge SC_TIMECOUNTER_CLOCK_50 or negedge SC_TIMECOUNTER_RESET_InLow) begin
        if (!SC_TIMECOUNTER_RESET_InLow) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            count_q   <= '0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (startFall) begin
            // A restart wins over a same-cycle terminal prescaler value.
            state_q   <= RUN;
            presc_q   <= '0;
            count_q   <= '0;
            tick_q    <= 1'b0;
            running_q <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
                RUN: begin
                    running_q <= 1'b1;
                    done_q    <= 1'b0;
                    if (!pauseActive) begin
                        if (presc_q == PRESC_LAST) begin
                            presc_q <= '0;
                            if (count_q < CNT_MAX) begin
                                count_q <= count_q + 8'd1;
                                tick_q  <= 1'b1;
                            end else if (WRAP != 1'b0) begin
                                count_q <= '0;
                                tick_q  <= 1'b1;
                            end else begin
                                state_q   <= DONE;
                                running_q <= 1'b0;
                                done_q    <= 1'b1;
                            end
                        end else begin
                            presc_q <= presc_q + 26'd1;
                        end
                    end
                end
                DONE: begin
                    running_q <= 1'b0;
                    done_q    <= 1'b1;
                end
                default: begin
                    state_q   <= IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign tc_if.SC_TIMECOUNTER_COUNT   = count_q;
    assign tc_if.SC_TIMECOUNTER_TICK    = tick_q;
    assign tc_if.SC_TIMECOUNTER_RUNNING = running_q;
    assign tc_if.SC_TIMECOUNTER_DONE    = done_q;

endmodule
